// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

  function automatic logic [6:0] nib_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_if.sv
// Producer-side bus of the 7-segment scan driver.
//   load/val/hex_mode/blank_lz : capture request from the numeric producer
//   busy                       : conversion in progress, load ignored
//   ovf                        : last accepted value did not fit the display
interface seg7_if #(parameter int WIDTH = 14);
  logic             load;
  logic [WIDTH-1:0] val;
  logic             hex_mode;
  logic             blank_lz;
  logic             busy;
  logic             ovf;

  modport master (output load, val, hex_mode, blank_lz, input busy, ovf);
  modport slave  (input load, val, hex_mode, blank_lz, output busy, ovf);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per cycle.
//   start : begin conversion of bin (honoured only while idle)
//   busy  : high for exactly WIDTH cycles after start
//   done  : high in the final conversion cycle; bcd/ovf valid in that cycle
//   bcd   : BCD result, 4*DIGITS bits
//   ovf   : a 1 was shifted out of the top nibble during this conversion
//
// state     | meaning
// CONV_IDLE | waiting for start
// CONV_RUN  | shifting, cnt = steps still to perform
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t      state;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    bcd_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    step;
  logic             lost;

  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  assign step = {adj[BW-2:0], sh[WIDTH-1]};
  assign lost = adj[BW-1];

  // The top module commits on the same edge that ends the last shift, so the
  // final result is presented combinationally from the step logic.
  assign done = (state == CONV_RUN) && (cnt == CW'(1));
  assign bcd  = step;
  assign ovf  = ovf_r | lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CONV_IDLE;
      sh    <= '0;
      bcd_r <= '0;
      ovf_r <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            state <= CONV_RUN;
            sh    <= bin;
            bcd_r <= '0;
            ovf_r <= 1'b0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
          end
        end
        default: begin
          sh    <= sh << 1;
          bcd_r <= step;
          ovf_r <= ovf_r | lost;
          if (cnt == CW'(1)) begin
            state <= CONV_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment display driver with sequential BCD or hex conversion
// and time-multiplexed, active-low segment/anode outputs.
//   clk, rst_n : system clock, async active-low reset
//   bus        : load/val/hex_mode/blank_lz in, busy/ovf out
//   seg        : shared segments {g,f,e,d,c,b,a}, active-low
//   an         : per-digit enables, active-low one-cold, an[0] rightmost
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_if.slave             bus,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int BW = 4 * DIGITS;
  localparam int EW = (WIDTH > BW) ? WIDTH : BW;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  logic              accept;
  logic              conv_busy;
  logic              conv_done;
  logic [BW-1:0]     conv_bcd;
  logic              conv_ovf;
  logic              hex_busy;
  logic [BW-1:0]     hex_nib;
  logic              hex_ovf;
  logic              pend_blank;
  logic [EW-1:0]     ext;
  logic [BW-1:0]     new_nib;
  logic              new_ovf;
  logic [DIGITS-1:0] new_blank;
  logic              zero_above;
  logic [BW-1:0]     disp;
  logic              disp_ovf;
  logic [DIGITS-1:0] disp_blank;
  logic [CW-1:0]     scan_cnt;
  logic [IW-1:0]     idx;
  logic [6:0]        cur_seg;

  assign bus.busy = conv_busy | hex_busy;
  assign bus.ovf  = disp_ovf;
  assign accept   = bus.load && !bus.busy;
  assign ext      = EW'(bus.val);

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && !bus.hex_mode),
    .bin   (bus.val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  assign new_nib = hex_busy ? hex_nib : conv_bcd;
  assign new_ovf = hex_busy ? hex_ovf : conv_ovf;

  // Leading-zero mask: digit i blanks when it and every digit above are zero.
  always_comb begin
    new_blank  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above && (new_nib[4*i +: 4] == 4'd0);
      new_blank[i] = pend_blank && zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_busy   <= 1'b0;
      hex_nib    <= '0;
      hex_ovf    <= 1'b0;
      pend_blank <= 1'b0;
      disp       <= '0;
      disp_ovf   <= 1'b0;
      disp_blank <= '0;
    end else begin
      hex_busy <= accept && bus.hex_mode;
      if (accept) begin
        pend_blank <= bus.blank_lz;
        hex_nib    <= ext[BW-1:0];
        hex_ovf    <= |(ext >> BW);
      end
      if (conv_done || hex_busy) begin
        disp       <= new_nib;
        disp_ovf   <= new_ovf;
        disp_blank <= new_blank;
      end
    end
  end

  always_comb begin
    if (disp_ovf)             cur_seg = SEG_DASH;
    else if (disp_blank[idx]) cur_seg = SEG_BLANK;
    else                      cur_seg = nib_to_seg(disp[4*idx +: 4]);
  end

  // seg/an reload only at the start of each slot, so a digit holds one
  // pattern for its whole SCAN_DIV-cycle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= SEG_BLANK;
      an       <= '1;
    end else begin
      if (scan_cnt == '0) begin
        seg <= cur_seg;
        an  <= ~(DIGITS'(1) << idx);
      end
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
    end
  end
endmodule
